// File: rtl/regfile_pkg.sv
// Shared IR field layout and sizing helpers for the general-purpose register file.
package regfile_pkg;

  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;
  localparam int C_MSB  = 18;

  localparam int FIELD_W          = RA_MSB - RA_LSB + 1;
  localparam int DEFAULT_NUM_REGS = 16;

  // A two-entry bank still needs a one-bit index, so never return zero.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/select_encode.sv
// IR field decode: picks the register index named by Gra/Grb/Grc and
// sign-extends the 19-bit constant field onto the bus width.
module select_encode
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 4
) (
  input  logic [31:0]           IR,
  input  logic                  Gra,
  input  logic                  Grb,
  input  logic                  Grc,
  output logic [IDX_W-1:0]      sel,
  output logic [IDX_W-1:0]      ra_idx,
  output logic                  sel_valid,
  output logic [DATA_WIDTH-1:0] C_sign_extended
);

  logic [FIELD_W-1:0] ra_field;
  logic [FIELD_W-1:0] rb_field;
  logic [FIELD_W-1:0] rc_field;
  logic               unused_ir_bits;

  assign ra_field = IR[RA_MSB:RA_LSB];
  assign rb_field = IR[RB_MSB:RB_LSB];
  assign rc_field = IR[RC_MSB:RC_LSB];

  // Smaller banks only look at the low index bits of each field.
  assign ra_idx = IDX_W'(ra_field);

  assign sel = Gra ? ra_idx :
               Grb ? IDX_W'(rb_field) :
                     IDX_W'(rc_field);

  assign sel_valid = Gra | Grb | Grc;

  assign C_sign_extended = DATA_WIDTH'($signed(IR[C_MSB:0]));

  assign unused_ir_bits = ^IR[31:RA_MSB+1];

endmodule

// File: rtl/gp_register_file.sv
// General-purpose register bank with IR-field select, R0 base-address gating
// and a per-register busy scoreboard. Optional debug read port: REGFILE_DEBUG_PORT_EN.
module gp_register_file
  import regfile_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = DEFAULT_NUM_REGS,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0,
  parameter int                    BA_GATE    = 1,
  localparam int                   IDX_W      = idx_width(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  enable,
  input  logic [31:0]           IR,
  input  logic                  Gra,
  input  logic                  Grb,
  input  logic                  Grc,
  input  logic                  Rin,
  input  logic                  Rout,
  input  logic                  BAout,
  input  logic                  issue,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
`ifdef REGFILE_DEBUG_PORT_EN
  input  logic [IDX_W-1:0]      dbg_idx,
  output logic [DATA_WIDTH-1:0] dbg_data,
`endif
  output logic [DATA_WIDTH-1:0] BusMuxIn,
  output logic [DATA_WIDTH-1:0] C_sign_extended,
  output logic                  hazard,
  output logic [NUM_REGS-1:0]   busy
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [IDX_W-1:0]      sel;
  logic [IDX_W-1:0]      ra_idx;
  logic                  sel_valid;
  logic                  rd;
  logic                  r0_gated;
  logic                  write_en;

  select_encode #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_select_encode (
    .IR              (IR),
    .Gra             (Gra),
    .Grb             (Grb),
    .Grc             (Grc),
    .sel             (sel),
    .ra_idx          (ra_idx),
    .sel_valid       (sel_valid),
    .C_sign_extended (C_sign_extended)
  );

  assign write_en = enable & Rin & sel_valid;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= INIT;
      end
    end else if (write_en) begin
      regs[sel] <= BusMuxOut;
    end
  end

  // Issue is applied after the write-back clear so a same-index set wins.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      busy <= '0;
    end else if (enable) begin
      if (Rin && sel_valid) begin
        busy[sel] <= 1'b0;
      end
      if (issue) begin
        busy[ra_idx] <= 1'b1;
      end
    end
  end

  assign rd       = Rout | BAout;
  assign r0_gated = (BA_GATE != 0) && BAout && (sel == '0);

  // Idle reads drive zero so the output can feed an OR-style bus mux.
  always_comb begin
    BusMuxIn = '0;
    hazard   = 1'b0;
    if (rd && sel_valid && !r0_gated) begin
      BusMuxIn = regs[sel];
      hazard   = busy[sel];
    end
  end

`ifdef REGFILE_DEBUG_PORT_EN
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= regs[dbg_idx];
    end
  end
`endif

endmodule

// File: tb/tb_gp_register_file.sv
// Self-checking bench for gp_register_file: directed scenarios plus a randomized
// run against an array-based reference model; two instances cover BA_GATE = 1 and 0.
module tb_gp_register_file;

  logic        clock;
  logic        clear_n;
  logic        enable;
  logic [31:0] IR;
  logic        Gra, Grb, Grc;
  logic        Rin, Rout, BAout, issue;
  logic [31:0] BusMuxOut;
  logic [31:0] BusMuxIn, bus_ng;
  logic [31:0] C_sign_extended, c_ng;
  logic        hazard, haz_ng;
  logic [15:0] busy, busy_ng;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [3:0]  dbg_idx;
  logic [31:0] dbg_data, dbg_data_ng;
`endif

  logic [31:0] m_regs [16];
  bit          m_busy [16];
  int          checks;
  int          failures;

  gp_register_file #(.DATA_WIDTH(32), .NUM_REGS(16), .BA_GATE(1)) dut (
    .clock(clock), .clear_n(clear_n), .enable(enable), .IR(IR),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .issue(issue), .BusMuxOut(BusMuxOut),
`ifdef REGFILE_DEBUG_PORT_EN
    .dbg_idx(dbg_idx), .dbg_data(dbg_data),
`endif
    .BusMuxIn(BusMuxIn), .C_sign_extended(C_sign_extended),
    .hazard(hazard), .busy(busy)
  );

  gp_register_file #(.DATA_WIDTH(32), .NUM_REGS(16), .BA_GATE(0)) dut_nogate (
    .clock(clock), .clear_n(clear_n), .enable(enable), .IR(IR),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .issue(issue), .BusMuxOut(BusMuxOut),
`ifdef REGFILE_DEBUG_PORT_EN
    .dbg_idx(dbg_idx), .dbg_data(dbg_data_ng),
`endif
    .BusMuxIn(bus_ng), .C_sign_extended(c_ng),
    .hazard(haz_ng), .busy(busy_ng)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] make_ir(input int ra, input int rb, input int rc, input int low);
    logic [31:0] v;
    v        = 32'(low) & 32'h7FFF;
    v[26:23] = 4'(ra);
    v[22:19] = 4'(rb);
    v[18:15] = 4'(rc);
    return v;
  endfunction

  function automatic int model_sel();
    if (Gra) return int'(IR[26:23]);
    if (Grb) return int'(IR[22:19]);
    return int'(IR[18:15]);
  endfunction

  function automatic bit model_gated(input bit gate);
    return gate && BAout && (model_sel() == 0);
  endfunction

  function automatic logic [31:0] exp_bus(input bit gate);
    if (!(Rout || BAout) || !(Gra || Grb || Grc) || model_gated(gate)) return 32'h0;
    return m_regs[model_sel()];
  endfunction

  function automatic logic exp_haz(input bit gate);
    if (!(Rout || BAout) || !(Gra || Grb || Grc) || model_gated(gate)) return 1'b0;
    return m_busy[model_sel()];
  endfunction

  function automatic logic [15:0] exp_busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_cext();
    logic [31:0] c;
    c = {13'h0, IR[18:0]};
    return IR[18] ? (c | 32'hFFF8_0000) : c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    enable = 1'b1; Gra = 0; Grb = 0; Grc = 0;
    Rin = 0; Rout = 0; BAout = 0; issue = 0;
  endtask

  // Advance one clock edge, updating the model from the inputs in effect at it.
  task automatic applyStimulus();
    int  s;
    int  ra;
    bit  wr;
    s  = model_sel();
    ra = int'(IR[26:23]);
    wr = enable && Rin && (Gra || Grb || Grc);
    @(posedge clock);
    if (clear_n && enable) begin
      if (wr) begin
        m_regs[s] = BusMuxOut;
        m_busy[s] = 1'b0;
      end
      if (issue) m_busy[ra] = 1'b1;
    end
    #1;
  endtask

  task automatic write_reg(input int idx, input logic [31:0] val);
    idle();
    Gra = 1; Rin = 1; IR = make_ir(idx, 0, 0, 0); BusMuxOut = val;
    applyStimulus();
    idle();
  endtask

  task automatic test_reset();
    idle();
    #1;
    checks++;
    if (BusMuxIn !== 32'h0 || hazard !== 1'b0 || busy !== 16'h0) begin
      failures++;
      $display("[TB] FAIL reset_hold: bus=%h hazard=%b busy=%h, expected 0/0/0", BusMuxIn, hazard, busy);
    end
    #1 clear_n = 1'b1;
    applyStimulus();
    for (int i = 0; i < 6; i++) begin
      idle();
      Gra = 1; Rin = 1; issue = 1;
      IR = make_ir(i + 8, 0, 0, 0); BusMuxOut = $urandom | 32'h1;
      applyStimulus();
      IR = make_ir(i + 1, 0, 0, 0); Rin = 1; issue = 1; BusMuxOut = $urandom;
      applyStimulus();
    end
    idle();
    Gra = 1; Rout = 1; IR = make_ir(13, 0, 0, 0);
    #1;
    checks++;
    if (BusMuxIn !== exp_bus(1) || hazard !== exp_haz(1)) begin
      failures++;
      $display("[TB] FAIL pre_reset_read: bus=%h hazard=%b, expected %h/%b", BusMuxIn, hazard, exp_bus(1), exp_haz(1));
    end
    clear_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (BusMuxIn !== 32'h0 || hazard !== 1'b0 || busy !== 16'h0) begin
      failures++;
      $display("[TB] FAIL async_reset: bus=%h hazard=%b busy=%h, expected 0/0/0", BusMuxIn, hazard, busy);
    end
    for (int i = 0; i < 16; i++) begin
      IR = make_ir(i, 0, 0, 0);
      #0.1;
      checks++;
      if (BusMuxIn !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_reg%0d: got %h expected 0", i, BusMuxIn);
      end
    end
    Rout = 0;
    #0.2;
    checks++;
    if (BusMuxIn !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_idle_bus: got %h expected 0", BusMuxIn);
    end
    clear_n = 1'b1;
    idle();
    applyStimulus();
  endtask

  task automatic test_write_read();
    write_reg(5, 32'hDEAD_BEEF);
    Gra = 1; Rout = 1; IR = make_ir(5, 0, 0, 0);
    #1;
    checks++;
    if (BusMuxIn !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL write_read: got %h expected %h", BusMuxIn, 32'hDEAD_BEEF);
    end
    // Read and write of the same register in one cycle returns the old value.
    Rin = 1; BusMuxOut = 32'h0BAD_F00D;
    #1;
    checks++;
    if (BusMuxIn !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL no_write_through: got %h expected %h", BusMuxIn, 32'hDEAD_BEEF);
    end
    applyStimulus();
    Rin = 0;
    #1;
    checks++;
    if (BusMuxIn !== 32'h0BAD_F00D) begin
      failures++;
      $display("[TB] FAIL write_next_cycle: got %h expected %h", BusMuxIn, 32'h0BAD_F00D);
    end
    idle();
    Rin = 1; IR = make_ir(5, 0, 0, 0); BusMuxOut = 32'h1111_2222;
    applyStimulus();
    idle();
    Gra = 1; Rout = 1; IR = make_ir(5, 0, 0, 0);
    #1;
    checks++;
    if (BusMuxIn !== 32'h0BAD_F00D) begin
      failures++;
      $display("[TB] FAIL rin_no_select: got %h expected %h", BusMuxIn, 32'h0BAD_F00D);
    end
    idle();
  endtask

  task automatic test_r0_gating();
    write_reg(0, 32'h1234);
    write_reg(6, 32'h6666);
    Grb = 1; Rout = 1; IR = make_ir(5, 0, 0, 0);
    #1;
    checks++;
    if (BusMuxIn !== 32'h1234 || bus_ng !== 32'h1234) begin
      failures++;
      $display("[TB] FAIL r0_rout: got %h/%h expected %h", BusMuxIn, bus_ng, 32'h1234);
    end
    Rout = 0; BAout = 1;
    #1;
    checks++;
    if (BusMuxIn !== 32'h0) begin
      failures++;
      $display("[TB] FAIL r0_baout_gated: got %h expected 0", BusMuxIn);
    end
    checks++;
    if (bus_ng !== 32'h1234) begin
      failures++;
      $display("[TB] FAIL r0_baout_nogate: got %h expected %h", bus_ng, 32'h1234);
    end
    IR = make_ir(5, 6, 0, 0);
    #1;
    checks++;
    if (BusMuxIn !== 32'h6666) begin
      failures++;
      $display("[TB] FAIL baout_nonzero: got %h expected %h", BusMuxIn, 32'h6666);
    end
    idle();
  endtask

  task automatic test_priority_ext();
    write_reg(3, 32'h3333_3333);
    write_reg(7, 32'h7777_7777);
    Gra = 1; Grb = 1; Grc = 1; Rout = 1; IR = make_ir(3, 7, 5, 0);
    #1;
    checks++;
    if (BusMuxIn !== 32'h3333_3333) begin
      failures++;
      $display("[TB] FAIL priority_gra: got %h expected %h", BusMuxIn, 32'h3333_3333);
    end
    Gra = 0;
    #1;
    checks++;
    if (BusMuxIn !== 32'h7777_7777) begin
      failures++;
      $display("[TB] FAIL priority_grb: got %h expected %h", BusMuxIn, 32'h7777_7777);
    end
    IR = 32'h0007_FFFF;
    #1;
    checks++;
    if (C_sign_extended !== 32'hFFFF_FFFF) begin
      failures++;
      $display("[TB] FAIL cext_neg: got %h expected %h", C_sign_extended, 32'hFFFF_FFFF);
    end
    IR = 32'h0003_FFFF;
    #1;
    checks++;
    if (C_sign_extended !== 32'h0003_FFFF) begin
      failures++;
      $display("[TB] FAIL cext_pos: got %h expected %h", C_sign_extended, 32'h0003_FFFF);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    issue = 1; IR = make_ir(9, 0, 0, 0);
    applyStimulus();
    idle();
    checks++;
    if (busy[9] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_set: got %b expected 1", busy[9]);
    end
    Grc = 1; Rout = 1; IR = make_ir(2, 4, 9, 0);
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hazard_rc: got %b expected 1", hazard);
    end
    idle();
    enable = 0; Gra = 1; Rin = 1; IR = make_ir(9, 0, 0, 0); BusMuxOut = 32'h9999;
    applyStimulus();
    checks++;
    if (busy[9] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL enable_freeze: got %b expected 1", busy[9]);
    end
    write_reg(9, 32'h0909);
    checks++;
    if (busy[9] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL busy_clear: got %b expected 0", busy[9]);
    end
    Gra = 1; Rin = 1; issue = 1; IR = make_ir(9, 0, 0, 0); BusMuxOut = 32'h9090;
    applyStimulus();
    idle();
    checks++;
    if (busy[9] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL set_wins: got %b expected 1", busy[9]);
    end
    checks++;
    if (busy !== exp_busy_vec()) begin
      failures++;
      $display("[TB] FAIL busy_vector: got %h expected %h", busy, exp_busy_vec());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      enable    = ($urandom_range(0, 7) != 0);
      IR        = $urandom;
      Gra       = $urandom_range(0, 3) == 0;
      Grb       = $urandom_range(0, 2) == 0;
      Grc       = $urandom_range(0, 1) == 0;
      Rin       = $urandom_range(0, 2) == 0;
      Rout      = $urandom_range(0, 1) == 0;
      BAout     = $urandom_range(0, 3) == 0;
      issue     = $urandom_range(0, 3) == 0;
      BusMuxOut = $urandom;
      #1;
      checks++;
      if (BusMuxIn !== exp_bus(1) || hazard !== exp_haz(1)) begin
        failures++;
        $display("[TB] FAIL rand_read_gate[%0d]: bus=%h hazard=%b, expected %h/%b", n, BusMuxIn, hazard, exp_bus(1), exp_haz(1));
      end
      checks++;
      if (bus_ng !== exp_bus(0) || haz_ng !== exp_haz(0)) begin
        failures++;
        $display("[TB] FAIL rand_read_nogate[%0d]: bus=%h hazard=%b, expected %h/%b", n, bus_ng, haz_ng, exp_bus(0), exp_haz(0));
      end
      checks++;
      if (C_sign_extended !== exp_cext()) begin
        failures++;
        $display("[TB] FAIL rand_cext[%0d]: got %h expected %h", n, C_sign_extended, exp_cext());
      end
      applyStimulus();
      checks++;
      if (busy !== exp_busy_vec() || busy_ng !== exp_busy_vec()) begin
        failures++;
        $display("[TB] FAIL rand_busy[%0d]: got %h/%h expected %h", n, busy, busy_ng, exp_busy_vec());
      end
    end
    idle();
  endtask

`ifdef REGFILE_DEBUG_PORT_EN
  task automatic test_debug();
    write_reg(3, 32'h3C3C_3C3C);
    dbg_idx = 4'd3;
    applyStimulus();
    write_reg(2, 32'hA5A5_A5A5);
    checks++;
    if (dbg_data !== 32'h3C3C_3C3C) begin
      failures++;
      $display("[TB] FAIL dbg_prev: got %h expected %h", dbg_data, 32'h3C3C_3C3C);
    end
    dbg_idx = 4'd2;
    #1;
    checks++;
    if (dbg_data !== 32'h3C3C_3C3C) begin
      failures++;
      $display("[TB] FAIL dbg_not_comb: got %h expected %h", dbg_data, 32'h3C3C_3C3C);
    end
    applyStimulus();
    checks++;
    if (dbg_data !== 32'hA5A5_A5A5) begin
      failures++;
      $display("[TB] FAIL dbg_latency: got %h expected %h", dbg_data, 32'hA5A5_A5A5);
    end
    write_reg(0, 32'h00C0_FFEE);
    dbg_idx = 4'd0; BAout = 1; Grb = 1; IR = make_ir(5, 0, 0, 0);
    applyStimulus();
    checks++;
    if (dbg_data !== 32'h00C0_FFEE) begin
      failures++;
      $display("[TB] FAIL dbg_no_gate: got %h expected %h", dbg_data, 32'h00C0_FFEE);
    end
    idle();
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    clear_n   = 1'b0;
    IR        = 32'h0;
    BusMuxOut = 32'h0;
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_idx   = 4'd0;
`endif
    idle();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_write_read();
    test_r0_gating();
    test_priority_ext();
    test_scoreboard();
    test_random();
`ifdef REGFILE_DEBUG_PORT_EN
    test_debug();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
